cdb_slot_scheduler: RTL and testbench

// - Writeback-slot reservation ring between issue and execute. Generalises the single-slot tag ring to
//   NUM_CDB broadcast slots per cycle and NUM_ISSUE issue ports, with per-class latency and branch-resolve mask clearing.
// - Grants issue only when a CDB slot is free in the completion cycle; emits early wakeup tags EARLY_WAKE cycles ahead.

---
 rtl/cdb_slot_scheduler.sv | 154 +++++++++++++++
 tb/tb_cdb_slot_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_slot_scheduler.sv
// Writeback-slot reservation ring: grants issue only when a CDB slot is free in the completion row.
// Optional macro CDB_SLOT_EX_REG_EN adds one cycle between issue and execute (target row shifts by 1).
module cdb_slot_scheduler #(
  parameter int RING_DEPTH = 16,
  parameter int NUM_CDB    = 2,
  parameter int NUM_ISSUE  = 2,
  parameter int ALU_LAT    = 1,
  parameter int MULT_LAT   = 4,
  parameter int EARLY_WAKE = 1,
  parameter int TAG_W      = 6,
  parameter int BMASK_W    = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   stall,
  input  logic [NUM_ISSUE-1:0]                   iss_valid,
  input  logic [NUM_ISSUE-1:0]                   iss_mult,
  input  logic [NUM_ISSUE*TAG_W-1:0]             iss_tag,
  input  logic [NUM_ISSUE*BMASK_W-1:0]           iss_bmask,
  output logic [NUM_ISSUE-1:0]                   iss_grant,
  input  logic                                   squash_valid,
  input  logic                                   resolve_valid,
  input  logic [BMASK_W-1:0]                     br_mask,
  output logic [NUM_CDB*TAG_W-1:0]               early_tag,
  output logic [NUM_CDB-1:0]                     early_valid,
  output logic [$clog2(RING_DEPTH*NUM_CDB+1)-1:0] occupancy
);

  localparam int IDX_W = $clog2(RING_DEPTH);
  localparam int OCC_W = $clog2(RING_DEPTH*NUM_CDB+1);
`ifdef CDB_SLOT_EX_REG_EN
  localparam int XR = 1;
`else
  localparam int XR = 0;
`endif
  localparam logic [IDX_W-1:0] ALU_OFS  = IDX_W'(ALU_LAT + XR);
  localparam logic [IDX_W-1:0] MULT_OFS = IDX_W'(MULT_LAT + XR);
  localparam logic [IDX_W-1:0] EW_OFS   = IDX_W'(EARLY_WAKE);

  logic [IDX_W-1:0]   head_reg, head_next;
  logic [NUM_CDB-1:0] valid_reg [RING_DEPTH];
  logic [NUM_CDB-1:0] valid_next [RING_DEPTH];
  logic [TAG_W-1:0]   tag_reg [RING_DEPTH][NUM_CDB];
  logic [TAG_W-1:0]   tag_next [RING_DEPTH][NUM_CDB];
  logic [BMASK_W-1:0] bmask_reg [RING_DEPTH][NUM_CDB];
  logic [BMASK_W-1:0] bmask_next [RING_DEPTH][NUM_CDB];
  logic [OCC_W-1:0]   occ_reg, occ_next;
  logic [IDX_W-1:0]   row_sel [NUM_ISSUE];
  logic [NUM_CDB-1:0] slot_sel [NUM_ISSUE];
  logic [IDX_W-1:0]   early_row;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ISSUE; gi++) begin : g_port
      assign row_sel[gi]   = head_reg + (iss_mult[gi] ? MULT_OFS : ALU_OFS);
      assign iss_grant[gi] = |slot_sel[gi];
    end
  endgenerate

  // Ports are served in priority order; each sees the slots claimed by the ports before it.
  always_comb begin : grant_comb
    logic [NUM_CDB-1:0] taken;
    logic [NUM_CDB-1:0] pick [NUM_ISSUE];
    logic               killed;
    for (int i = 0; i < NUM_ISSUE; i++) begin
      pick[i] = '0;
      taken   = valid_reg[row_sel[i]];
      for (int j = 0; j < NUM_ISSUE; j++) begin
        if (j < i && row_sel[j] == row_sel[i]) taken = taken | pick[j];
      end
      killed = squash_valid && (|(iss_bmask[i*BMASK_W +: BMASK_W] & br_mask));
      if (iss_valid[i] && !stall && !reset && !killed) begin
        for (int s = NUM_CDB - 1; s >= 0; s--) begin
          if (!taken[s]) begin
            pick[i]    = '0;
            pick[i][s] = 1'b1;
          end
        end
      end
      slot_sel[i] = pick[i];
    end
  end

  always_comb begin : next_comb
    int count;
    valid_next = valid_reg;
    tag_next   = tag_reg;
    bmask_next = bmask_reg;
    for (int r = 0; r < RING_DEPTH; r++) begin
      for (int s = 0; s < NUM_CDB; s++) begin
        if (squash_valid) begin
          if (|(bmask_reg[r][s] & br_mask)) valid_next[r][s] = 1'b0;
        end else if (resolve_valid) begin
          bmask_next[r][s] = bmask_reg[r][s] & ~br_mask;
        end
      end
    end
    if (!stall) valid_next[head_reg] = '0;
    for (int i = 0; i < NUM_ISSUE; i++) begin
      for (int s = 0; s < NUM_CDB; s++) begin
        if (slot_sel[i][s]) begin
          valid_next[row_sel[i]][s] = 1'b1;
          tag_next[row_sel[i]][s]   = iss_tag[i*TAG_W +: TAG_W];
          bmask_next[row_sel[i]][s] = (resolve_valid && !squash_valid) ?
                                      (iss_bmask[i*BMASK_W +: BMASK_W] & ~br_mask) :
                                      iss_bmask[i*BMASK_W +: BMASK_W];
        end
      end
    end
    head_next = stall ? head_reg : head_reg + 1'b1;
    count = 0;
    for (int r = 0; r < RING_DEPTH; r++) begin
      for (int s = 0; s < NUM_CDB; s++) count = count + int'(valid_next[r][s]);
    end
    occ_next = OCC_W'(count);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg <= '0;
      occ_reg  <= '0;
      for (int r = 0; r < RING_DEPTH; r++) begin
        valid_reg[r] <= '0;
        for (int s = 0; s < NUM_CDB; s++) begin
          tag_reg[r][s]   <= '0;
          bmask_reg[r][s] <= '0;
        end
      end
    end else begin
      head_reg  <= head_next;
      occ_reg   <= occ_next;
      valid_reg <= valid_next;
      tag_reg   <= tag_next;
      bmask_reg <= bmask_next;
    end
  end

  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ISSUE; i++) assert ((valid_reg[row_sel[i]] & slot_sel[i]) == '0);
    end
  end

  assign early_row = head_reg + EW_OFS;
  generate
    for (gi = 0; gi < NUM_CDB; gi++) begin : g_early
      assign early_tag[gi*TAG_W +: TAG_W] = tag_reg[early_row][gi];
      assign early_valid[gi] = valid_reg[early_row][gi] & ~stall & ~reset;
    end
  endgenerate

  assign occupancy = occ_reg;

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Bench for cdb_slot_scheduler: directed literal scenarios plus randomized traffic against a
// reservation-list model keyed by absolute completion cycle.
module tb_cdb_slot_scheduler;
  localparam int RD = 16, NC = 2, NI = 2, AL = 1, ML = 4, EW = 1, TW = 6, BW = 4;
  localparam int OW = $clog2(RD*NC+1);
`ifdef CDB_SLOT_EX_REG_EN
  localparam int XR = 1;
`else
  localparam int XR = 0;
`endif

  logic clock = 1'b0;
  logic reset, stall, squash_valid, resolve_valid;
  logic [NI-1:0] iss_valid, iss_mult, iss_grant;
  logic [NI*TW-1:0] iss_tag;
  logic [NI*BW-1:0] iss_bmask;
  logic [BW-1:0] br_mask;
  logic [NC*TW-1:0] early_tag;
  logic [NC-1:0] early_valid;
  logic [OW-1:0] occupancy;

  always #5 clock = ~clock;

  cdb_slot_scheduler #(.RING_DEPTH(RD), .NUM_CDB(NC), .NUM_ISSUE(NI), .ALU_LAT(AL), .MULT_LAT(ML),
                       .EARLY_WAKE(EW), .TAG_W(TW), .BMASK_W(BW)) dut (
    .clock(clock), .reset(reset), .stall(stall), .iss_valid(iss_valid), .iss_mult(iss_mult),
    .iss_tag(iss_tag), .iss_bmask(iss_bmask), .iss_grant(iss_grant), .squash_valid(squash_valid),
    .resolve_valid(resolve_valid), .br_mask(br_mask), .early_tag(early_tag),
    .early_valid(early_valid), .occupancy(occupancy));

  typedef struct {int due; int slot; logic [TW-1:0] tag; logic [BW-1:0] bmask;} res_t;
  res_t q[$];
  int step;
  int checks, failures;
  logic [NI-1:0] exp_grant;
  int exp_due[NI];
  int exp_slot[NI];
  logic [NI-1:0] last_grant;
  logic [NC-1:0] last_ev;
  logic [NC*TW-1:0] last_et;
  logic [OW-1:0] last_occ;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_grant();
    exp_grant = '0;
    for (int i = 0; i < NI; i++) begin
      logic [BW-1:0] bm;
      logic [NC-1:0] used;
      int due;
      exp_due[i] = 0;
      exp_slot[i] = 0;
      bm = iss_bmask[i*BW +: BW];
      if (reset || stall || !iss_valid[i] || (squash_valid && (bm & br_mask) != 0)) continue;
      due = step + (iss_mult[i] ? ML : AL) + XR;
      used = '0;
      foreach (q[k]) if (q[k].due == due) used[q[k].slot] = 1'b1;
      for (int j = 0; j < i; j++) if (exp_grant[j] && exp_due[j] == due) used[exp_slot[j]] = 1'b1;
      for (int s = 0; s < NC; s++) begin
        if (!used[s]) begin
          exp_grant[i] = 1'b1;
          exp_due[i] = due;
          exp_slot[i] = s;
          break;
        end
      end
    end
  endtask

  task automatic compare();
    model_grant();
    last_grant = iss_grant;
    last_ev = early_valid;
    last_et = early_tag;
    last_occ = occupancy;
    chk("grant", int'(iss_grant), int'(exp_grant));
    for (int s = 0; s < NC; s++) begin
      logic found;
      logic [TW-1:0] t;
      found = 1'b0;
      t = '0;
      foreach (q[k]) if (q[k].due == step + EW && q[k].slot == s) begin found = 1'b1; t = q[k].tag; end
      found = found && !stall && !reset;
      chk($sformatf("early_valid[%0d]", s), int'(early_valid[s]), int'(found));
      if (found) chk($sformatf("early_tag[%0d]", s), int'(early_tag[s*TW +: TW]), int'(t));
    end
    chk("occupancy", int'(occupancy), q.size());
  endtask

  task automatic model_edge();
    if (reset) begin
      q.delete();
      step = 0;
      return;
    end
    if (squash_valid) begin
      for (int k = q.size() - 1; k >= 0; k--) if ((q[k].bmask & br_mask) != 0) q.delete(k);
    end else if (resolve_valid) begin
      for (int k = 0; k < q.size(); k++) q[k].bmask = q[k].bmask & ~br_mask;
    end
    if (!stall) begin
      for (int k = q.size() - 1; k >= 0; k--) if (q[k].due == step) q.delete(k);
      for (int i = 0; i < NI; i++) begin
        if (exp_grant[i]) begin
          res_t r;
          r.due = exp_due[i];
          r.slot = exp_slot[i];
          r.tag = iss_tag[i*TW +: TW];
          r.bmask = (resolve_valid && !squash_valid) ? (iss_bmask[i*BW +: BW] & ~br_mask)
                                                      : iss_bmask[i*BW +: BW];
          q.push_back(r);
        end
      end
      step++;
    end
  endtask

  task automatic tick();
    #1;
    compare();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic idle();
    iss_valid = '0; iss_mult = '0; iss_tag = '0; iss_bmask = '0;
    squash_valid = 1'b0; resolve_valid = 1'b0; br_mask = '0; stall = 1'b0;
  endtask

  task automatic req(input logic [NI-1:0] v, input logic [NI-1:0] m, input logic [TW-1:0] t0,
                     input logic [TW-1:0] t1, input logic [BW-1:0] b0, input logic [BW-1:0] b1);
    iss_valid = v; iss_mult = m; iss_tag = {t1, t0}; iss_bmask = {b1, b0};
  endtask

  initial begin
    checks = 0; failures = 0; step = 0;
    idle();
    reset = 1'b1;
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);

    // Requests while in reset are never granted.
    req(2'b11, 2'b00, 6'd5, 6'd6, 4'd0, 4'd0);
    tick();
    chk("reset_grant", int'(last_grant), 0);
    chk("reset_early_valid", int'(last_ev), 0);
    chk("reset_occupancy", int'(last_occ), 0);
    reset = 1'b0;

    // Two ALU tags at head 0 both land in row 1.
    req(2'b11, 2'b00, 6'd5, 6'd6, 4'd0, 4'd0);
    tick();
    chk("alu_pair_grant", int'(last_grant), 3);
    idle();
    tick();
    chk("alu_pair_occ", int'(last_occ), 2);
    tick();
    chk("alu_pair_drained", int'(last_occ), 0);

    // MULT at head 0 and two ALU at head 3 share row 4.
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    req(2'b01, 2'b01, 6'd9, 6'd0, 4'd0, 4'd0);
    tick();
    chk("mult_grant", int'(last_grant), 1);
    idle(); tick(); tick();
    req(2'b11, 2'b00, 6'd3, 6'd4, 4'd0, 4'd0);
    tick();
    chk("row_full_grant", int'(last_grant), 1);
    chk("row_full_early_valid", int'(last_ev), 1);
    chk("row_full_early_tag", int'(last_et[TW-1:0]), 9);
    idle();
    tick();
    chk("row_full_occ", int'(last_occ), 2);
    tick();
    chk("row_full_drained", int'(last_occ), 0);

    // Squash / resolve / stall sequence on two MULT entries.
    req(2'b11, 2'b11, 6'd1, 6'd2, 4'b0010, 4'b0100);
    tick();
    chk("br_pair_grant", int'(last_grant), 3);
    idle(); squash_valid = 1'b1; br_mask = 4'b0010;
    tick();
    chk("pre_squash_occ", int'(last_occ), 2);
    idle(); resolve_valid = 1'b1; br_mask = 4'b0100;
    tick();
    chk("post_squash_occ", int'(last_occ), 1);
    idle(); stall = 1'b1; squash_valid = 1'b1; br_mask = 4'b0100;
    req(2'b11, 2'b00, 6'd7, 6'd8, 4'd0, 4'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_grant", int'(last_grant), 0);
      chk("stall_early_valid", int'(last_ev), 0);
      chk("stall_occ", int'(last_occ), 1);
      squash_valid = 1'b0;
    end
    idle();
    tick();
    chk("resolved_early_valid", int'(last_ev), 2);
    chk("resolved_early_tag", int'(last_et[2*TW-1:TW]), 2);
    chk("resolved_occ", int'(last_occ), 1);

    // 40 cycles of MULT tags through a wrapping head.
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      req(2'b01, 2'b01, TW'(c + 1), 6'd0, 4'd0, 4'd0);
      tick();
      if (c >= 3) begin
        chk("wrap_early_valid", int'(last_ev), 1);
        chk("wrap_early_tag", int'(last_et[TW-1:0]), c - 2);
      end
    end

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 6) == 0);
      iss_valid = NI'($urandom);
      iss_mult = NI'($urandom);
      iss_tag = (NI*TW)'($urandom);
      iss_bmask = (NI*BW)'($urandom & $urandom);
      squash_valid = ($urandom_range(0, 8) == 0);
      resolve_valid = ($urandom_range(0, 4) == 0);
      br_mask = BW'(1 << $urandom_range(0, BW - 1));
      tick();
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
